// File: rtl/merge_seq_ctrl.sv
// Sequencer for an external two-block merge unit: collects blocks A and B, strobes them in, waits out the merge latency, holds the result.
// Optional input-order checking is built when MERGE_ORDER_CHECK_EN is defined; otherwise err is tied low.
module merge_seq_ctrl #(
  parameter int WIDTH     = 8,
  parameter int N         = 4,
  parameter int MERGE_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*WIDTH-1:0]     in_data,
  output logic [1:0]             m_load,
  output logic [2*N*WIDTH-1:0]   m_inba,
  input  logic [2*N*WIDTH-1:0]   m_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*N*WIDTH-1:0]   out_data,
  output logic                   busy,
  output logic [15:0]            blk_cnt,
  output logic                   err
);

  localparam int BW = N * WIDTH;
  localparam logic [3:0] LAT_M1 = 4'(MERGE_LAT - 1);

  typedef enum logic [2:0] {IDLE, GET_B, LOAD_A, LOAD_B, WAIT, OUT} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [BW-1:0]     r_a;
  logic [BW-1:0]     r_b;
  logic [2*BW-1:0]   r_out;
  logic [3:0]        r_cnt;
  logic [15:0]       r_blk_cnt;
  logic              r_in_ready;
  logic              w_acc;

  assign w_acc = in_valid && r_in_ready;

  always_comb begin
    w_next    = r_state;
    m_load    = 2'b00;
    out_valid = 1'b0;
    case (r_state)
      IDLE:   if (w_acc) w_next = GET_B;
      GET_B:  if (w_acc) w_next = LOAD_A;
      LOAD_A: begin
        m_load = 2'b01;
        w_next = LOAD_B;
      end
      LOAD_B: begin
        m_load = 2'b10;
        w_next = WAIT;
      end
      WAIT:   if (r_cnt == 4'd0) w_next = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // in_ready is registered so it stays low through reset and rises on the first edge after it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_in_ready <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_out      <= '0;
      r_cnt      <= '0;
      r_blk_cnt  <= '0;
    end else begin
      r_state    <= w_next;
      r_in_ready <= (w_next == IDLE) || (w_next == GET_B);
      if (r_state == IDLE && w_acc) r_a <= in_data;
      if (r_state == GET_B && w_acc) r_b <= in_data;
      if (r_state == LOAD_B) r_cnt <= LAT_M1;
      else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
      if (r_state == WAIT && r_cnt == 4'd0) r_out <= m_c;
      if (r_state == OUT && out_ready) r_blk_cnt <= r_blk_cnt + 16'd1;
    end
  end

  assign in_ready = r_in_ready;
  assign m_inba   = {r_b, r_a};
  assign out_data = r_out;
  assign busy     = (r_state != IDLE);
  assign blk_cnt  = r_blk_cnt;

`ifdef MERGE_ORDER_CHECK_EN
  logic w_unsorted;
  logic r_err;

  always_comb begin
    w_unsorted = 1'b0;
    for (int i = 0; i < N - 1; i++) begin
      if (in_data[i*WIDTH +: WIDTH] > in_data[(i+1)*WIDTH +: WIDTH]) w_unsorted = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else if (w_acc && w_unsorted) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_merge_seq_ctrl.sv
// Bench for merge_seq_ctrl with a sorting merge-unit model; expected err depends on MERGE_ORDER_CHECK_EN.
module tb_merge_seq_ctrl;
  localparam int W = 8;
  localparam int N = 4;
  localparam int LAT = 2;
`ifdef MERGE_ORDER_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [N*W-1:0]    in_data = '0;
  logic [1:0]        m_load;
  logic [2*N*W-1:0]  m_inba;
  logic [2*N*W-1:0]  m_c;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [2*N*W-1:0]  out_data;
  logic              busy;
  logic [15:0]       blk_cnt;
  logic              err;

  merge_seq_ctrl #(.WIDTH(W), .N(N), .MERGE_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_load(m_load), .m_inba(m_inba), .m_c(m_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .blk_cnt(blk_cnt), .err(err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int failed = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int pairs_loaded = 0;
  int n01 = 0, n10 = 0, n11 = 0;
  logic [1:0] prev_ld = 2'b00;
  logic [2*N*W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    failed++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic logic [31:0] pack4(input logic [7:0] e0, e1, e2, e3);
    return {e3, e2, e1, e0};
  endfunction

  function automatic logic [63:0] sort8(input logic [63:0] v);
    logic [7:0] e[8];
    logic [7:0] t;
    logic [63:0] r;
    for (int i = 0; i < 8; i++) e[i] = v[i*8 +: 8];
    for (int i = 0; i < 7; i++)
      for (int j = 0; j < 7 - i; j++)
        if (e[j] > e[j+1]) begin t = e[j]; e[j] = e[j+1]; e[j+1] = t; end
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = e[i];
    return r;
  endfunction

  // Merge-unit model: captures operands on the load strobes, result garbage until B is loaded
  logic [31:0] mdl_a = '0, mdl_b = '0;
  logic        mdl_ok = 1'b0;
  always @(posedge clk) begin
    if (m_load[0]) begin mdl_a <= m_inba[31:0]; mdl_ok <= 1'b0; end
    if (m_load[1]) begin mdl_b <= m_inba[63:32]; mdl_ok <= 1'b1; end
  end
  assign m_c = mdl_ok ? sort8({mdl_b, mdl_a}) : 64'hDEAD_BEEF_DEAD_BEEF;

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) fail_now("unexpected_output");
      else check("out_data", out_data, exp_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (prev_ld == 2'b01) check("m_load_seq", {62'd0, m_load}, 64'd2);
    if (m_load == 2'b01) n01++;
    if (m_load == 2'b10) n10++;
    if (m_load == 2'b11) n11++;
    prev_ld = m_load;
  end

  task automatic send_block(input logic [31:0] d);
    int n;
    logic got;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      got = in_ready;
      @(posedge clk);
      if (got) break;
      n++;
      if (n > 50) begin fail_now("in_ready"); break; end
      @(negedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    acc_cyc  = cyc;
  endtask

  task automatic run_pair(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int n;
    exp_q.push_back(exp);
    send_block(a);
    send_block(b);
    pairs_loaded++;
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    if (!out_valid) fail_now("out_valid");
    else check("latency", 64'(cyc - acc_cyc), 64'(LAT + 2));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (out_valid && n < 100) begin @(negedge clk); n++; end
    if (out_valid) fail_now("handshake");
  endtask

  logic [63:0] held;

  initial begin
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_m_load", m_load, 0);
    check("rst_blk_cnt", blk_cnt, 0);
    check("rst_err", err, 0);
    check("rst_out_data", out_data, 0);
    check("rst_m_inba", m_inba, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("in_ready_after_rst", in_ready, 1);

    // Basic merge
    run_pair(pack4(0, 0, 200, 201), pack4(1, 1, 9, 23),
             {8'd201, 8'd200, 8'd23, 8'd9, 8'd1, 8'd1, 8'd0, 8'd0});
    check("m_inba_hold", m_inba, {pack4(1, 1, 9, 23), pack4(0, 0, 200, 201)});
    wait_done();
    check("blk_cnt_1", blk_cnt, 1);
    check("busy_idle", busy, 0);

    // Output stall with in_valid pulses that must be ignored
    out_ready = 1'b0;
    run_pair(pack4(10, 20, 30, 40), pack4(15, 25, 35, 45),
             {8'd45, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10});
    held = {8'd45, 8'd40, 8'd35, 8'd30, 8'd25, 8'd20, 8'd15, 8'd10};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_data", out_data, held);
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", out_valid, 1);
      check("stall_blk_cnt", blk_cnt, 1);
      in_valid = i[0];
      in_data  = $urandom;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_done();
    check("blk_cnt_2", blk_cnt, 2);

    // Reset in the middle of WAIT
    exp_q.push_back({8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    send_block(pack4(1, 2, 3, 4));
    send_block(pack4(5, 6, 7, 8));
    pairs_loaded++;
    @(negedge clk);
    @(negedge clk);
    check("wait_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_m_load", m_load, 0);
    check("mid_rst_blk_cnt", blk_cnt, 0);
    check("mid_rst_m_inba", m_inba, 0);
    check("mid_rst_out_data", out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", out_valid, 0);
    end
    run_pair(pack4(3, 3, 3, 3), pack4(0, 4, 4, 255),
             {8'd255, 8'd4, 8'd4, 8'd3, 8'd3, 8'd3, 8'd3, 8'd0});
    wait_done();
    check("blk_cnt_after_rst", blk_cnt, 1);
    check("err_clean", err, 0);

    // Unsorted A block
    run_pair(pack4(5, 3, 7, 9), pack4(1, 2, 3, 4),
             {8'd9, 8'd7, 8'd5, 8'd4, 8'd3, 8'd3, 8'd2, 8'd1});
    wait_done();
    check("err_order", err, EXP_ERR);
    check("blk_cnt_order", blk_cnt, 2);

    // Counter wrap
    @(negedge clk);
    force dut.r_blk_cnt = 16'hFFFE;
    #1;
    release dut.r_blk_cnt;
    run_pair(pack4(1, 2, 3, 4), pack4(1, 2, 3, 4),
             {8'd4, 8'd4, 8'd3, 8'd3, 8'd2, 8'd2, 8'd1, 8'd1});
    wait_done();
    check("wrap_ffff", blk_cnt, 16'hFFFF);
    run_pair(pack4(0, 1, 2, 3), pack4(4, 5, 6, 7),
             {8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0});
    wait_done();
    check("wrap_0000", blk_cnt, 16'h0000);
    run_pair(pack4(9, 9, 9, 9), pack4(8, 8, 8, 8),
             {8'd9, 8'd9, 8'd9, 8'd9, 8'd8, 8'd8, 8'd8, 8'd8});
    wait_done();
    check("wrap_0001", blk_cnt, 16'h0001);
    check("err_sticky", err, EXP_ERR);

    repeat (3) @(negedge clk);
    check("pending_outputs", 64'(exp_q.size()), 0);
    check("m_load_01_count", 64'(n01), 64'(pairs_loaded));
    check("m_load_10_count", 64'(n10), 64'(pairs_loaded));
    check("m_load_11_count", 64'(n11), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
